branch_unit_bht: RTL and testbench
==================================

Name: branch_unit_bht

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Resolves the branch condition for the execute-stage instruction and keeps a PC-indexed table of 2-bit saturating counters that gives fetch a taken/not-taken prediction.
- Registers a one-cycle-latency resolution result: taken, mispredict and redirect PC.
- Keeps saturating branch and mispredict statistics counters.
- Sits between the fetch PC mux (prediction) and the execute stage (resolution) of the 3-stage pipeline.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of counters; must be a power of 2, minimum 4.
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pc_f  in  XLEN  fetch-stage PC
- pred_taken_f  out  1  prediction for pc_f
- ex_valid  in  1  execute-stage instruction valid
- flush  in  1  kill execute-stage instruction
- br_type  in  3  branch operation, br_type_e encoding
- A, B  in  XLEN  comparison operands
- pc_e  in  XLEN  execute-stage PC
- target_e  in  XLEN  computed branch/jump target
- pred_taken_e  in  1  prediction carried down the pipe with the instruction
- res_valid  out  1  registered: a resolution happened last cycle
- res_taken  out  1  registered resolved direction
- mispredict  out  1  registered: redirect required
- redirect_pc  out  XLEN  registered correct next PC
- br_count  out  STAT_W  conditional branches resolved
- mp_count  out  STAT_W  mispredicts

Behaviour:
- Index: idx = PC[IDX_W+1:2], where IDX_W = $clog2(BHT_DEPTH). The same slice is used for pc_f and pc_e.
- Prediction is combinational: pred_taken_f = bht[idx_f][1]. It reads table contents before any same-cycle update (old value on an index collision).
- Condition evaluation for br_type:
  - beq: A==B.
  - bne: A!=B.
  - blt: signed A<B.
  - bge: signed A>=B.
  - bltu: unsigned A<B.
  - bgeu: unsigned A>=B.
  - jump: always taken.
  - no_jump: never taken.
- Only the 6 funct3-derived types above count as conditional.
- Active when go = ex_valid & ~flush.
- On the next clock edge after go:
  - res_valid=1.
  - res_taken = taken.
  - mispredict = (taken != pred_taken_e).
  - redirect_pc = taken ? target_e : pc_e+4 (mod 2^XLEN wrap).
- When go=0: res_valid=0 and mispredict=0. res_taken and redirect_pc hold their previous values.
- Latency is exactly 1 cycle. There is no stall or back-pressure, and back-to-back resolutions are supported every cycle.
- BHT update happens only when go is set and br_type is conditional:
  - taken: counter increments and saturates at 2'b11.
  - not taken: counter decrements and saturates at 2'b00.
- jump and no_jump never modify the table. A predicted-taken no_jump still raises mispredict with redirect to pc_e+4.
- Statistics:
  - br_count increments on each conditional go.
  - mp_count increments on each go with a mispredict (any type).
  - Both saturate at all-ones; they never wrap.
- flush and ex_valid together: flush wins. No update, no stats, res_valid=0.
- rst has priority over all inputs. It sets every BHT entry to CTR_INIT and clears res_valid, res_taken, mispredict, redirect_pc, br_count and mp_count to 0.
- A resolution in flight during rst is discarded.
- Reset values of outputs: all 0. pred_taken_f = CTR_INIT[1] = 0.

Decomposition:
- Header package holds:
  - br_type_e enum: beq=0, bne=1, no_jump=2, jump=3, blt=4, bge=5, bltu=6, bgeu=7.
  - BUS_WIDTH default.
  - Counter constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Function is_cond(br_type_e).
- One sub-module, sat_counter2: a 2-bit saturating up/down counter with enable and synchronous reset to CTR_INIT. It is instantiated BHT_DEPTH times in a generate loop.
- Condition logic stays inline as a function.

Test Plan:
1. Reset, then pc_f sweep 0x00..0xFC: pred_taken_f=0 for all. br_count=0 and mp_count=0.
2. blt with A=0xFFFFFFFF, B=1, pc_e=0x40, target_e=0x80, pred_taken_e=0, XLEN=32 -> next cycle: res_taken=1, mispredict=1, redirect_pc=0x80. bht[16] becomes 2'b10, so pred_taken_f=1 at pc_f=0x40. Same operands with bltu -> not taken.
3. Four consecutive taken beq at pc 0x10: counter saturates at 11 (reads show 10, 11, 11, 11). Then two not-taken: 10, then 01 (prediction flips to 0 on the second).
4. pc_e=0xFFFFFFFC, bne not taken (A==B), pred_taken_e=1 -> mispredict=1, redirect_pc=0x00000000 (wrap).
5. ex_valid=1 and flush=1 on a taken bge -> res_valid=0, no BHT change, counters unchanged. jump with pred_taken_e=1 -> mispredict=0, br_count unchanged.
6. STAT_W=4: 20 mispredicting conditional branches -> mp_count=0xF and br_count=0xF, held. Assert rst mid-stream -> all counters and outputs cleared next cycle.

Source files
------------

// File: rtl/branch_unit_bht_pkg.sv
// Shared types and constants for the branch resolution unit and its
// branch history table of 2-bit saturating counters.
package branch_unit_bht_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  typedef enum logic [2:0] {
    BR_BEQ     = 3'd0,
    BR_BNE     = 3'd1,
    BR_NO_JUMP = 3'd2,
    BR_JUMP    = 3'd3,
    BR_BLT     = 3'd4,
    BR_BGE     = 3'd5,
    BR_BLTU    = 3'd6,
    BR_BGEU    = 3'd7
  } br_type_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Only the funct3-derived compare types train the predictor and count as branches.
  function automatic logic is_cond(input br_type_e t);
    return (t != BR_JUMP) && (t != BR_NO_JUMP);
  endfunction

endpackage

// File: rtl/branch_unit_bht_sat_counter2.sv
// One BHT entry: 2-bit saturating up/down counter with enable and
// synchronous reset to a configurable initial state.
module sat_counter2
  import branch_unit_bht_pkg::*;
#(
  parameter logic [1:0] CTR_INIT = CTR_WNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  logic [1:0] ctr_q;
  logic [1:0] ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (en_i) begin
      if (up_i && (ctr_q != CTR_ST)) begin
        ctr_d = ctr_q + 2'd1;
      end else if (!up_i && (ctr_q != CTR_SNT)) begin
        ctr_d = ctr_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= CTR_INIT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_unit_bht.sv
// Branch condition resolution with a PC-indexed 2-bit counter predictor,
// one-cycle registered resolution result and saturating statistics.
module branch_unit_bht
  import branch_unit_bht_pkg::*;
#(
  parameter int unsigned XLEN      = BUS_WIDTH,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = CTR_WNT,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_f,
  output logic              pred_taken_f,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [2:0]        br_type,
  input  logic [XLEN-1:0]   A,
  input  logic [XLEN-1:0]   B,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   target_e,
  input  logic              pred_taken_e,
  output logic              res_valid,
  output logic              res_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  function automatic logic eval_cond(input br_type_e t,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic r;
    r = 1'b0;
    case (t)
      BR_BEQ:     r = (a == b);
      BR_BNE:     r = (a != b);
      BR_BLT:     r = ($signed(a) <  $signed(b));
      BR_BGE:     r = ($signed(a) >= $signed(b));
      BR_BLTU:    r = (a <  b);
      BR_BGEU:    r = (a >= b);
      BR_JUMP:    r = 1'b1;
      BR_NO_JUMP: r = 1'b0;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  br_type_e         bt;
  logic             go;
  logic             cond;
  logic             taken;
  logic             bht_upd;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [1:0]       bht [BHT_DEPTH];

  assign bt      = br_type_e'(br_type);
  assign go      = ex_valid & ~flush;
  assign cond    = is_cond(bt);
  assign taken   = eval_cond(bt, A, B);
  assign bht_upd = go & cond;
  assign idx_f   = pc_f[IDX_W+1:2];
  assign idx_e   = pc_e[IDX_W+1:2];

  // PC bits outside the index slice do not participate in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0]};

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    sat_counter2 #(
      .CTR_INIT (CTR_INIT)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en_i  (bht_upd && (idx_e == IDX_W'(i))),
      .up_i  (taken),
      .ctr_o (bht[i])
    );
  end

  // Reads the pre-update table state, so a same-cycle collision sees the old value.
  assign pred_taken_f = bht[idx_f][1];

  logic              res_valid_q,   res_valid_d;
  logic              res_taken_q,   res_taken_d;
  logic              mispredict_q,  mispredict_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [STAT_W-1:0] br_count_q,    br_count_d;
  logic [STAT_W-1:0] mp_count_q,    mp_count_d;

  always_comb begin
    res_valid_d   = go;
    mispredict_d  = go & (taken != pred_taken_e);
    res_taken_d   = res_taken_q;
    redirect_pc_d = redirect_pc_q;
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;
    if (go) begin
      res_taken_d   = taken;
      redirect_pc_d = taken ? target_e : XLEN'(pc_e + XLEN'(4));
      if (cond && (br_count_q != '1)) begin
        br_count_d = br_count_q + STAT_W'(1);
      end
      if (mispredict_d && (mp_count_q != '1)) begin
        mp_count_d = mp_count_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed bench for branch_unit_bht (STAT_W=4 so statistics saturation is reachable).
module tb_branch_unit_bht;
  import branch_unit_bht_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAT_W = 4;

  logic              clk;
  logic              rst;
  logic [XLEN-1:0]   pc_f;
  logic              pred_taken_f;
  logic              ex_valid;
  logic              flush;
  logic [2:0]        br_type;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [XLEN-1:0]   pc_e;
  logic [XLEN-1:0]   target_e;
  logic              pred_taken_e;
  logic              res_valid;
  logic              res_taken;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mp_count;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_unit_bht #(
    .XLEN      (XLEN),
    .BHT_DEPTH (64),
    .CTR_INIT  (2'b01),
    .STAT_W    (STAT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .pred_taken_f (pred_taken_f),
    .ex_valid     (ex_valid),
    .flush        (flush),
    .br_type      (br_type),
    .A            (A),
    .B            (B),
    .pc_e         (pc_e),
    .target_e     (target_e),
    .pred_taken_e (pred_taken_e),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .br_count     (br_count),
    .mp_count     (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".br_count"}, XLEN'(br_count), XLEN'(exp_br));
    chk({tag, ".mp_count"}, XLEN'(mp_count), XLEN'(exp_mp));
  endtask

  task automatic check_pred(input string tag, input logic [XLEN-1:0] pc, input logic exp);
    pc_f = pc;
    #1;
    chk(tag, XLEN'(pred_taken_f), XLEN'(exp));
  endtask

  // One resolution cycle; exp_taken is hand-derived by the caller.
  task automatic resolve(input string tag, input br_type_e t,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input logic pred, input logic exp_taken);
    logic            exp_mp_bit;
    logic [XLEN-1:0] exp_pc;
    exp_mp_bit = (exp_taken != pred);
    exp_pc     = exp_taken ? tgt : pc + 32'd4;
    ex_valid = 1'b1; flush = 1'b0;
    br_type = t; A = a; B = b; pc_e = pc; target_e = tgt; pred_taken_e = pred;
    tick();
    ex_valid = 1'b0;
    if (is_cond(t) && exp_br < 15) exp_br++;
    if (exp_mp_bit && exp_mp < 15) exp_mp++;
    chk({tag, ".res_valid"}, XLEN'(res_valid), 32'd1);
    chk({tag, ".res_taken"}, XLEN'(res_taken), XLEN'(exp_taken));
    chk({tag, ".mispredict"}, XLEN'(mispredict), XLEN'(exp_mp_bit));
    chk({tag, ".redirect_pc"}, redirect_pc, exp_pc);
    chk_stats(tag);
  endtask

  initial begin
    rst = 1'b1; pc_f = '0; ex_valid = 1'b0; flush = 1'b0; br_type = 3'd0;
    A = '0; B = '0; pc_e = '0; target_e = '0; pred_taken_e = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state and prediction sweep
    chk("rst.res_valid", XLEN'(res_valid), 32'd0);
    chk("rst.res_taken", XLEN'(res_taken), 32'd0);
    chk("rst.mispredict", XLEN'(mispredict), 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk_stats("rst");
    for (int i = 0; i < 64; i++) begin
      check_pred("rst.pred_sweep", XLEN'(i * 4), 1'b0);
    end

    // Signed vs unsigned compare on the same operands
    resolve("blt", BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 1'b0, 1'b1);
    check_pred("blt.pred", 32'h40, 1'b1);
    tick();
    chk("idle.res_valid", XLEN'(res_valid), 32'd0);
    chk("idle.mispredict", XLEN'(mispredict), 32'd0);
    chk("idle.res_taken_hold", XLEN'(res_taken), 32'd1);
    chk("idle.redirect_hold", redirect_pc, 32'h80);
    resolve("bltu", BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 1'b1, 1'b0);
    check_pred("bltu.pred", 32'h40, 1'b0);

    // Saturation at strongly taken, then decay back to weakly not-taken
    resolve("beq_t1", BR_BEQ, 32'd5, 32'd5, 32'h10, 32'h200, 1'b0, 1'b1);
    check_pred("beq_t1.pred", 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      resolve("beq_tn", BR_BEQ, 32'd5, 32'd5, 32'h10, 32'h200, 1'b1, 1'b1);
      check_pred("beq_tn.pred", 32'h10, 1'b1);
    end
    resolve("beq_nt1", BR_BEQ, 32'd5, 32'd6, 32'h10, 32'h200, 1'b1, 1'b0);
    check_pred("beq_nt1.pred", 32'h10, 1'b1);
    resolve("beq_nt2", BR_BEQ, 32'd5, 32'd6, 32'h10, 32'h200, 1'b1, 1'b0);
    check_pred("beq_nt2.pred", 32'h10, 1'b0);

    // Fall-through PC wraps at the top of the address space
    resolve("bne_wrap", BR_BNE, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h300, 1'b1, 1'b0);

    // Flush wins over ex_valid: no result, no training, no stats
    ex_valid = 1'b1; flush = 1'b1; br_type = BR_BGE; A = 32'd3; B = 32'd1;
    pc_e = 32'h20; target_e = 32'h400; pred_taken_e = 1'b0;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    chk("flush.res_valid", XLEN'(res_valid), 32'd0);
    chk("flush.mispredict", XLEN'(mispredict), 32'd0);
    chk_stats("flush");
    check_pred("flush.pred", 32'h20, 1'b0);

    // Unconditional types: no table update, no branch count
    resolve("jump", BR_JUMP, 32'd0, 32'd0, 32'h30, 32'h100, 1'b1, 1'b1);
    check_pred("jump.pred", 32'h30, 1'b0);
    resolve("no_jump", BR_NO_JUMP, 32'd0, 32'd0, 32'h34, 32'h500, 1'b1, 1'b0);
    check_pred("no_jump.pred", 32'h34, 1'b0);

    // Mispredicting taken branches drive both statistics into saturation
    for (int i = 0; i < 20; i++) begin
      resolve("sat", BR_BGEU, 32'd9, 32'd2, 32'h80, 32'h600, 1'b0, 1'b1);
    end
    chk("sat.br_count_max", XLEN'(br_count), 32'hF);
    chk("sat.mp_count_max", XLEN'(mp_count), 32'hF);
    tick();
    chk("sat.br_count_held", XLEN'(br_count), 32'hF);
    chk("sat.mp_count_held", XLEN'(mp_count), 32'hF);
    check_pred("sat.pred", 32'h80, 1'b1);

    // Reset with a resolution in flight discards it and clears everything
    rst = 1'b1; ex_valid = 1'b1; flush = 1'b0; br_type = BR_BEQ;
    A = 32'd1; B = 32'd1; pc_e = 32'h80; target_e = 32'h700; pred_taken_e = 1'b0;
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    exp_br = 0; exp_mp = 0;
    chk("rst2.res_valid", XLEN'(res_valid), 32'd0);
    chk("rst2.res_taken", XLEN'(res_taken), 32'd0);
    chk("rst2.mispredict", XLEN'(mispredict), 32'd0);
    chk("rst2.redirect_pc", redirect_pc, 32'd0);
    chk_stats("rst2");
    check_pred("rst2.pred", 32'h80, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
